// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serialising memory controller.
// Access-size codes match the core's load/store unit encoding.
package mem_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Index of the final byte of an access; the unused code 11 behaves as a word.
  function automatic logic [1:0] last_byte(input logic [1:0] sel);
    case (sel)
      MEM_BYTE: return 2'd0;
      MEM_HALF: return 2'd1;
      default:  return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Core-side request/response ports plus the byte-wide RAM port of mem_ctrl.
// slave = the controller, master = whoever drives requests and models the RAM.
interface mem_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17
);

  logic              if_req_i;
  logic [XLEN-1:0]   if_addr_i;
  logic [XLEN-1:0]   if_data_o;
  logic              if_done_o;

  logic              mem_req_i;
  logic              mem_we_i;
  logic [1:0]        mem_sel_i;
  logic [XLEN-1:0]   mem_addr_i;
  logic [XLEN-1:0]   mem_wdata_i;
  logic [XLEN-1:0]   mem_rdata_o;
  logic              mem_done_o;

  logic              stallreq_o;

  logic [ADDR_W-1:0] ram_a_o;
  logic              ram_wr_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    input  ram_din_i,
    output if_data_o, if_done_o, mem_rdata_o, mem_done_o, stallreq_o,
    output ram_a_o, ram_wr_o, ram_dout_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    output ram_din_i,
    input  if_data_o, if_done_o, mem_rdata_o, mem_done_o, stallreq_o,
    input  ram_a_o, ram_wr_o, ram_dout_o
  );

endinterface

// File: rtl/mem_ctrl.sv
// Serialises 32-bit fetch and load/store requests onto a byte-wide RAM with
// 1-cycle read latency; the MEM port wins when both ports request together.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  state_t            state_reg;
  logic              port_mem_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        last_reg;
  logic [1:0]        k_reg;
  logic              iss_reg;
  logic              rd_vld_reg;
  logic [1:0]        rd_idx_reg;
  logic [XLEN-1:0]   wdata_reg;
  logic [XLEN-1:0]   buf_reg;

  logic [ADDR_W-1:0] ram_a_reg;
  logic              ram_wr_reg;
  logic [7:0]        ram_dout_reg;
  logic              if_done_reg;
  logic              mem_done_reg;
  logic [XLEN-1:0]   if_data_reg;
  logic [XLEN-1:0]   mem_rdata_reg;

  logic              acc_valid;
  logic              acc_mem;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [1:0]        acc_last;

  always_comb begin
    acc_valid = bus.mem_req_i | bus.if_req_i;
    acc_mem   = bus.mem_req_i;
    acc_we    = bus.mem_req_i & bus.mem_we_i;
    acc_addr  = bus.mem_req_i ? bus.mem_addr_i[ADDR_W-1:0] : bus.if_addr_i[ADDR_W-1:0];
    acc_last  = bus.mem_req_i ? last_byte(bus.mem_sel_i) : 2'd3;
  end

  // Address of the following byte; the ADDR_W-wide add wraps at the top of RAM.
  logic [1:0]        k_next;
  logic [ADDR_W-1:0] a_next;
  assign k_next = k_reg + 2'd1;
  assign a_next = addr_reg + ADDR_W'(k_next);

  logic [7:0]      wbyte [4];
  logic [XLEN-1:0] merged;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wbyte[gi]         = wdata_reg[8*gi +: 8];
      assign merged[8*gi +: 8] = (rd_idx_reg == 2'(gi)) ? bus.ram_din_i : buf_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      port_mem_reg  <= 1'b0;
      addr_reg      <= '0;
      last_reg      <= 2'd0;
      k_reg         <= 2'd0;
      iss_reg       <= 1'b0;
      rd_vld_reg    <= 1'b0;
      rd_idx_reg    <= 2'd0;
      wdata_reg     <= '0;
      buf_reg       <= '0;
      ram_a_reg     <= '0;
      ram_wr_reg    <= 1'b0;
      ram_dout_reg  <= 8'h00;
      if_done_reg   <= 1'b0;
      mem_done_reg  <= 1'b0;
      if_data_reg   <= '0;
      mem_rdata_reg <= '0;
    end else begin
      if_done_reg  <= 1'b0;
      mem_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (acc_valid) begin
            port_mem_reg <= acc_mem;
            addr_reg     <= acc_addr;
            last_reg     <= acc_last;
            wdata_reg    <= bus.mem_wdata_i;
            k_reg        <= 2'd0;
            buf_reg      <= '0;
            rd_vld_reg   <= 1'b0;
            ram_a_reg    <= acc_addr;
            if (acc_we) begin
              ram_wr_reg   <= 1'b1;
              ram_dout_reg <= bus.mem_wdata_i[7:0];
              state_reg    <= ST_WRITE;
            end else begin
              iss_reg   <= 1'b1;
              state_reg <= ST_READ;
            end
          end
        end
        ST_READ: begin
          // Issue and capture are pipelined: byte k is captured one cycle after its address.
          if (iss_reg) begin
            rd_vld_reg <= 1'b1;
            rd_idx_reg <= k_reg;
            if (k_reg == last_reg) begin
              iss_reg   <= 1'b0;
              ram_a_reg <= '0;
            end else begin
              k_reg     <= k_next;
              ram_a_reg <= a_next;
            end
          end else begin
            rd_vld_reg <= 1'b0;
          end
          if (rd_vld_reg) begin
            buf_reg <= merged;
            if (rd_idx_reg == last_reg) begin
              rd_vld_reg <= 1'b0;
              state_reg  <= ST_DONE;
              if (port_mem_reg) begin
                mem_rdata_reg <= merged;
                mem_done_reg  <= 1'b1;
              end else begin
                if_data_reg <= merged;
                if_done_reg <= 1'b1;
              end
            end
          end
        end
        ST_WRITE: begin
          if (k_reg == last_reg) begin
            ram_wr_reg   <= 1'b0;
            ram_a_reg    <= '0;
            ram_dout_reg <= 8'h00;
            mem_done_reg <= 1'b1;
            state_reg    <= ST_DONE;
          end else begin
            k_reg        <= k_next;
            ram_a_reg    <= a_next;
            ram_dout_reg <= wbyte[k_next];
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.ram_a_o     = ram_a_reg;
  assign bus.ram_wr_o    = ram_wr_reg;
  assign bus.ram_dout_o  = ram_dout_reg;
  assign bus.if_done_o   = if_done_reg;
  assign bus.if_data_o   = if_data_reg;
  assign bus.mem_done_o  = mem_done_reg;
  assign bus.mem_rdata_o = mem_rdata_reg;
  assign bus.stallreq_o  = (bus.if_req_i & ~if_done_reg) | (bus.mem_req_i & ~mem_done_reg);

  // Request address bits above the RAM size are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr_i[XLEN-1:ADDR_W], bus.mem_addr_i[XLEN-1:ADDR_W]};

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: expectations are queued when a request is
// driven and popped when the matching done pulse appears.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int ADDR_W = 17;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   wr_cnt = 0;

  exp_t mem_q[$];
  exp_t if_q[$];
  logic [7:0]        ram [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] a_seq [4];

  mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
  mem_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM model: registered read, one cycle of latency.
  always @(posedge clk) begin
    bus.ram_din_i <= ram[bus.ram_a_o];
    if (bus.ram_wr_o) ram[bus.ram_a_o] = bus.ram_dout_o;
  end

  always @(negedge clk) if (bus.ram_wr_o) wr_cnt = wr_cnt + 1;

  task automatic start_mem(input logic we, input logic [1:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_data, input int lat);
    bus.mem_req_i   = 1'b1;
    bus.mem_we_i    = we;
    bus.mem_sel_i   = sel;
    bus.mem_addr_i  = addr;
    bus.mem_wdata_i = wdata;
    wr_cnt = 0;
    mem_q.push_back('{data: exp_data, lat: lat, t0: cyc});
  endtask

  task automatic start_if(input logic [31:0] addr, input logic [31:0] exp_data, input int lat);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = addr;
    if_q.push_back('{data: exp_data, lat: lat, t0: cyc});
  endtask

  task automatic release_req(input logic is_mem);
    @(posedge clk);
    #1;
    if (is_mem) bus.mem_req_i = 1'b0;
    else bus.if_req_i = 1'b0;
  endtask

  task automatic wait_done(input logic is_mem, output logic seen, output int t, output int stall_lo);
    seen = 1'b0;
    t = 0;
    stall_lo = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (is_mem ? bus.mem_done_o : bus.if_done_o) begin
        seen = 1'b1;
        t = cyc;
      end else if (!bus.stallreq_o) begin
        stall_lo++;
      end
    end
  endtask

  // Called in the accept cycle; records ram_a_o over the next four cycles.
  task automatic capture_addr();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_seq[i] = bus.ram_a_o;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.ram_a_o !== '0 || bus.ram_wr_o !== 1'b0 || bus.ram_dout_o !== 8'h00) $display("FAIL reset_ram: got a=%h wr=%b dout=%h required all 0", bus.ram_a_o, bus.ram_wr_o, bus.ram_dout_o); else n_pass++;
    n_checks++; if ({bus.if_done_o, bus.mem_done_o} !== 2'b00) $display("FAIL reset_done: got %b required 00", {bus.if_done_o, bus.mem_done_o}); else n_pass++;
    n_checks++; if ({bus.if_data_o, bus.mem_rdata_o} !== 64'h0) $display("FAIL reset_data: got %h required 0", {bus.if_data_o, bus.mem_rdata_o}); else n_pass++;
    n_checks++; if (bus.stallreq_o !== 1'b0) $display("FAIL reset_stall: got %b required 0", bus.stallreq_o); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    logic seen; int t, slo; exp_t e;
    start_if(32'h0000_0100, 32'h00A0_0513, 6);
    wait_done(1'b0, seen, t, slo);
    n_checks++;
    if (!seen || if_q.size() == 0) $display("FAIL fetch_done: got no if_done_o required one within 40 cycles");
    else begin
      n_pass++;
      e = if_q.pop_front();
      n_checks++; if (bus.if_data_o !== e.data) $display("FAIL fetch_data: got %h required %h", bus.if_data_o, e.data); else n_pass++;
      n_checks++; if (t - e.t0 !== e.lat) $display("FAIL fetch_latency: got %0d required %0d", t - e.t0, e.lat); else n_pass++;
    end
    n_checks++; if (slo !== 0) $display("FAIL fetch_stall: got %0d low cycles required 0", slo); else n_pass++;
    release_req(1'b0);
    @(negedge clk);
    n_checks++; if (bus.stallreq_o !== 1'b0) $display("FAIL fetch_stall_idle: got %b required 0", bus.stallreq_o); else n_pass++;
  endtask

  task automatic test_subword_load();
    logic seen; int t, slo; exp_t e;
    start_mem(1'b0, MEM_BYTE, 32'h0000_0020, 32'h0, 32'h0000_00F0, 3);
    wait_done(1'b1, seen, t, slo);
    n_checks++;
    if (!seen || mem_q.size() == 0) $display("FAIL byte_load_done: got no mem_done_o required one");
    else begin
      n_pass++;
      e = mem_q.pop_front();
      n_checks++; if (bus.mem_rdata_o !== e.data) $display("FAIL byte_load_data: got %h required %h", bus.mem_rdata_o, e.data); else n_pass++;
      n_checks++; if (t - e.t0 !== e.lat) $display("FAIL byte_load_latency: got %0d required %0d", t - e.t0, e.lat); else n_pass++;
    end
    release_req(1'b1);
    start_mem(1'b0, MEM_HALF, 32'h0000_0020, 32'h0, 32'h0000_8FF0, 4);
    wait_done(1'b1, seen, t, slo);
    n_checks++;
    if (!seen || mem_q.size() == 0) $display("FAIL half_load_done: got no mem_done_o required one");
    else begin
      n_pass++;
      e = mem_q.pop_front();
      n_checks++; if (bus.mem_rdata_o !== e.data) $display("FAIL half_load_data: got %h required %h", bus.mem_rdata_o, e.data); else n_pass++;
      n_checks++; if (t - e.t0 !== e.lat) $display("FAIL half_load_latency: got %0d required %0d", t - e.t0, e.lat); else n_pass++;
    end
    release_req(1'b1);
  endtask

  task automatic test_store();
    logic seen; int t, slo; exp_t e;
    // A store must leave mem_rdata_o at the last load value.
    start_mem(1'b1, MEM_WORD, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_8FF0, 5);
    wait_done(1'b1, seen, t, slo);
    n_checks++;
    if (!seen || mem_q.size() == 0) $display("FAIL word_store_done: got no mem_done_o required one");
    else begin
      n_pass++;
      e = mem_q.pop_front();
      n_checks++; if (bus.mem_rdata_o !== e.data) $display("FAIL word_store_rdata_hold: got %h required %h", bus.mem_rdata_o, e.data); else n_pass++;
      n_checks++; if (t - e.t0 !== e.lat) $display("FAIL word_store_latency: got %0d required %0d", t - e.t0, e.lat); else n_pass++;
      n_checks++; if (wr_cnt !== 4) $display("FAIL word_store_wr_cycles: got %0d required 4", wr_cnt); else n_pass++;
      n_checks++; if ({ram[32'h43], ram[32'h42], ram[32'h41], ram[32'h40]} !== 32'hDEAD_BEEF) $display("FAIL word_store_bytes: got %h required deadbeef", {ram[32'h43], ram[32'h42], ram[32'h41], ram[32'h40]}); else n_pass++;
    end
    release_req(1'b1);
    start_mem(1'b0, 2'b11, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 6);
    wait_done(1'b1, seen, t, slo);
    n_checks++;
    if (!seen || mem_q.size() == 0) $display("FAIL word_load_done: got no mem_done_o required one");
    else begin
      n_pass++;
      e = mem_q.pop_front();
      n_checks++; if (bus.mem_rdata_o !== e.data) $display("FAIL word_load_data: got %h required %h", bus.mem_rdata_o, e.data); else n_pass++;
      n_checks++; if (t - e.t0 !== e.lat) $display("FAIL word_load_latency: got %0d required %0d", t - e.t0, e.lat); else n_pass++;
    end
    release_req(1'b1);
    start_mem(1'b1, MEM_BYTE, 32'h0000_0050, 32'h1234_56A5, 32'hDEAD_BEEF, 2);
    wait_done(1'b1, seen, t, slo);
    n_checks++;
    if (!seen || mem_q.size() == 0) $display("FAIL byte_store_done: got no mem_done_o required one");
    else begin
      n_pass++;
      e = mem_q.pop_front();
      n_checks++; if (bus.mem_rdata_o !== e.data) $display("FAIL byte_store_rdata_hold: got %h required %h", bus.mem_rdata_o, e.data); else n_pass++;
      n_checks++; if (t - e.t0 !== e.lat) $display("FAIL byte_store_latency: got %0d required %0d", t - e.t0, e.lat); else n_pass++;
      n_checks++; if ({ram[32'h51], ram[32'h50]} !== 16'h00A5 || wr_cnt !== 1) $display("FAIL byte_store_bytes: got %h wr=%0d required 00a5 wr=1", {ram[32'h51], ram[32'h50]}, wr_cnt); else n_pass++;
    end
    release_req(1'b1);
  endtask

  task automatic test_simultaneous();
    logic seen; int t, slo, slo2; exp_t e;
    // MEM byte load wins; the fetch is accepted in the IDLE cycle after MEM's DONE.
    start_mem(1'b0, MEM_BYTE, 32'h0000_0021, 32'h0, 32'h0000_008F, 3);
    start_if(32'h0000_0040, 32'hDEAD_BEEF, 3 + 1 + 6);
    wait_done(1'b1, seen, t, slo);
    n_checks++;
    if (!seen || mem_q.size() == 0) $display("FAIL simul_mem_done: got no mem_done_o required one");
    else begin
      n_pass++;
      e = mem_q.pop_front();
      n_checks++; if (bus.mem_rdata_o !== e.data) $display("FAIL simul_mem_data: got %h required %h", bus.mem_rdata_o, e.data); else n_pass++;
      n_checks++; if (t - e.t0 !== e.lat) $display("FAIL simul_mem_latency: got %0d required %0d", t - e.t0, e.lat); else n_pass++;
      n_checks++; if (bus.if_done_o !== 1'b0) $display("FAIL simul_if_early: got if_done_o=%b required 0", bus.if_done_o); else n_pass++;
    end
    release_req(1'b1);
    wait_done(1'b0, seen, t, slo2);
    n_checks++;
    if (!seen || if_q.size() == 0) $display("FAIL simul_if_done: got no if_done_o required one");
    else begin
      n_pass++;
      e = if_q.pop_front();
      n_checks++; if (bus.if_data_o !== e.data) $display("FAIL simul_if_data: got %h required %h", bus.if_data_o, e.data); else n_pass++;
      n_checks++; if (t - e.t0 !== e.lat) $display("FAIL simul_if_latency: got %0d required %0d", t - e.t0, e.lat); else n_pass++;
    end
    n_checks++; if (slo + slo2 !== 0) $display("FAIL simul_stall: got %0d low cycles required 0", slo + slo2); else n_pass++;
    release_req(1'b0);
  endtask

  task automatic test_wrap();
    logic seen; int t, slo; exp_t e;
    logic [ADDR_W-1:0] exp_a [4];
    exp_a = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
    start_mem(1'b0, MEM_WORD, 32'h0001_FFFE, 32'h0, 32'h4433_2211, 6);
    capture_addr();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (a_seq[i] !== exp_a[i]) $display("FAIL wrap_addr%0d: got %h required %h", i, a_seq[i], exp_a[i]); else n_pass++;
    end
    wait_done(1'b1, seen, t, slo);
    n_checks++;
    if (!seen || mem_q.size() == 0) $display("FAIL wrap_done: got no mem_done_o required one");
    else begin
      n_pass++;
      e = mem_q.pop_front();
      n_checks++; if (bus.mem_rdata_o !== e.data) $display("FAIL wrap_data: got %h required %h", bus.mem_rdata_o, e.data); else n_pass++;
      n_checks++; if (t - e.t0 !== e.lat) $display("FAIL wrap_latency: got %0d required %0d", t - e.t0, e.lat); else n_pass++;
    end
    release_req(1'b1);
  endtask

  task automatic test_reset_mid();
    logic seen; int t, slo; exp_t e;
    logic [ADDR_W-1:0] exp_a [4];
    exp_a = '{17'h00040, 17'h00041, 17'h00042, 17'h00043};
    start_mem(1'b0, MEM_WORD, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 6);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (bus.ram_a_o !== 17'h00041) $display("FAIL rstmid_second_byte: got %h required 00041", bus.ram_a_o); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.ram_a_o !== '0 || bus.ram_wr_o !== 1'b0 || bus.ram_dout_o !== 8'h00) $display("FAIL rstmid_ram: got a=%h wr=%b dout=%h required all 0", bus.ram_a_o, bus.ram_wr_o, bus.ram_dout_o); else n_pass++;
    n_checks++; if ({bus.if_done_o, bus.mem_done_o} !== 2'b00 || {bus.if_data_o, bus.mem_rdata_o} !== 64'h0) $display("FAIL rstmid_outputs: got done=%b data=%h required 0", {bus.if_done_o, bus.mem_done_o}, {bus.if_data_o, bus.mem_rdata_o}); else n_pass++;
    mem_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_q.push_back('{data: 32'hDEAD_BEEF, lat: 6, t0: cyc});
    capture_addr();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (a_seq[i] !== exp_a[i]) $display("FAIL rstmid_addr%0d: got %h required %h", i, a_seq[i], exp_a[i]); else n_pass++;
    end
    wait_done(1'b1, seen, t, slo);
    n_checks++;
    if (!seen || mem_q.size() == 0) $display("FAIL rstmid_done: got no mem_done_o required one");
    else begin
      n_pass++;
      e = mem_q.pop_front();
      n_checks++; if (bus.mem_rdata_o !== e.data) $display("FAIL rstmid_data: got %h required %h", bus.mem_rdata_o, e.data); else n_pass++;
      n_checks++; if (t - e.t0 !== e.lat) $display("FAIL rstmid_latency: got %0d required %0d", t - e.t0, e.lat); else n_pass++;
    end
    release_req(1'b1);
  endtask

  initial begin
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = 32'h0;
    bus.mem_req_i   = 1'b0;
    bus.mem_we_i    = 1'b0;
    bus.mem_sel_i   = 2'b00;
    bus.mem_addr_i  = 32'h0;
    bus.mem_wdata_i = 32'h0;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'h00;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'hA0; ram[32'h103] = 8'h00;
    ram[32'h20]  = 8'hF0; ram[32'h21]  = 8'h8F; ram[32'h22]  = 8'h77; ram[32'h23]  = 8'h66;
    ram[32'h1FFFE] = 8'h11; ram[32'h1FFFF] = 8'h22; ram[32'h0] = 8'h33; ram[32'h1] = 8'h44;

    test_reset();
    test_fetch();
    test_subword_load();
    test_store();
    test_simultaneous();
    test_wrap();
    test_reset_mid();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
